ofm_writeback: RTL

Output-side counterpart of the weight/IFM BRAM loaders. It captures the 16 OFM byte lanes from the PE cluster on each `valid` event and packs each set into four 32-bit words. It then writes those words through a ready/enable write port into the OFM BRAM, using a channel-last layout. A 2-deep capture FIFO decouples PE result timing from write-port backpressure.

---
 rtl/ofm_writeback.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ofm_writeback.sv
// OFM writeback: captures 16-lane PE result sets into a small FIFO and drains
// them as packed 32-bit words to the OFM BRAM in channel-last order.
module ofm_writeback #(
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        OFM_W,
    input  logic [7:0]        OFM_C,
    input  logic [15:0]       valid,
    input  logic [7:0]        OFM_0,
    input  logic [7:0]        OFM_1,
    input  logic [7:0]        OFM_2,
    input  logic [7:0]        OFM_3,
    input  logic [7:0]        OFM_4,
    input  logic [7:0]        OFM_5,
    input  logic [7:0]        OFM_6,
    input  logic [7:0]        OFM_7,
    input  logic [7:0]        OFM_8,
    input  logic [7:0]        OFM_9,
    input  logic [7:0]        OFM_10,
    input  logic [7:0]        OFM_11,
    input  logic [7:0]        OFM_12,
    input  logic [7:0]        OFM_13,
    input  logic [7:0]        OFM_14,
    input  logic [7:0]        OFM_15,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [15:0][7:0] bytes;
        logic [15:0]      mask;
    } entry_t;

    state_t state_q, state_d;

    // Configuration latched on start
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        ofm_c_q;
    logic [6:0]        wpp_q;
    logic [15:0]       npix_m1_q;
    logic [3:0]        last_t_q;
    logic [1:0]        last_kmax_q;

    // Capture FIFO
    entry_t           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Drain counters (advance on accepted writes only)
    logic [1:0]        k_q, k_d;
    logic [15:0]       p_q, p_d;
    logic [3:0]        t_q, t_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;

    // Capture counters (stop accepting sets once the full frame is in)
    logic [15:0] cap_p_q, cap_p_d;
    logic [3:0]  cap_t_q, cap_t_d;
    logic        cap_all_q, cap_all_d;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              overflow_q, overflow_d;

    logic [15:0][7:0] lane_in;
    entry_t           in_set;
    entry_t           head_d;
    logic             start_go;
    logic             accept;
    logic [1:0]       kmax;
    logic             last_word;
    logic             final_set;
    logic             pop;
    logic             push_req;
    logic             push;
    logic             drop;
    logic [CNT_W-1:0] count_after_pop;
    logic [8:0]       rem_ch;
    logic [3:0]       lane_idx;
    logic             lane_keep;

    assign lane_in = {OFM_15, OFM_14, OFM_13, OFM_12, OFM_11, OFM_10, OFM_9, OFM_8,
                      OFM_7, OFM_6, OFM_5, OFM_4, OFM_3, OFM_2, OFM_1, OFM_0};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        in_set.mask = valid;
        for (int i = 0; i < 16; i++) begin
            in_set.bytes[i] = valid[i] ? lane_in[i] : 8'h00;
        end
    end

    assign start_go  = (state_q == S_IDLE) && start;
    assign accept    = wr_en_q && wr_ready;
    assign kmax      = (t_q == last_t_q) ? last_kmax_q : 2'd3;
    assign last_word = (k_q == kmax);
    assign final_set = (t_q == last_t_q) && (p_q == npix_m1_q);
    assign pop       = accept && last_word;
    assign push_req  = (state_q == S_RUN) && (|valid) && !cap_all_q;
    // Pop-before-push: a full FIFO still takes a set if its head retires this cycle
    assign push      = push_req && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
    assign drop      = push_req && !push;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = ((OFM_C == 8'd0) || (OFM_W == 8'd0)) ? S_DONE : S_RUN;
            S_RUN:  if (pop && final_set) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        k_d        = k_q;
        p_d        = p_q;
        t_d        = t_q;
        pix_addr_d = pix_addr_q;
        cap_p_d    = cap_p_q;
        cap_t_d    = cap_t_q;
        cap_all_d  = cap_all_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (start_go) begin
            k_d        = '0;
            p_d        = '0;
            t_d        = '0;
            pix_addr_d = base_addr;
            cap_p_d    = '0;
            cap_t_d    = '0;
            cap_all_d  = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (accept) begin
                if (last_word) begin
                    k_d = '0;
                    if (p_q == npix_m1_q) begin
                        p_d        = '0;
                        pix_addr_d = base_q;
                        t_d        = t_q + 4'd1;
                    end else begin
                        p_d        = p_q + 16'd1;
                        pix_addr_d = pix_addr_q + ADDR_W'(wpp_q);
                    end
                end else begin
                    k_d = k_q + 2'd1;
                end
            end

            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);

            if (push) begin
                if (cap_p_q == npix_m1_q) begin
                    cap_p_d = '0;
                    if (cap_t_q == last_t_q) cap_all_d = 1'b1;
                    else                     cap_t_d   = cap_t_q + 4'd1;
                end else begin
                    cap_p_d = cap_p_q + 16'd1;
                end
            end

            if (drop) overflow_d = 1'b1;
        end
    end

    // Outputs are registered from next-state values, so a set pushed into an
    // empty FIFO is presented on the very next cycle.
    assign count_after_pop = count_q - CNT_W'(pop);

    always_comb begin
        head_d    = (count_after_pop == '0) ? in_set : fifo_mem[rd_ptr_d];
        wr_en_d   = (state_d == S_RUN) && (count_d != '0);
        wr_addr_d = '0;
        wr_data_d = '0;
        rem_ch    = {1'b0, ofm_c_q} - {1'b0, t_d, 4'b0000};
        lane_idx  = '0;
        lane_keep = 1'b0;
        if (wr_en_d) begin
            wr_addr_d = pix_addr_d + ADDR_W'({t_d, k_d});
            for (int j = 0; j < 4; j++) begin
                lane_idx  = {k_d, 2'(j)};
                lane_keep = head_d.mask[lane_idx] && ({5'b0, lane_idx} < rem_ch);
                wr_data_d[8*j +: 8] = lane_keep ? head_d.bytes[lane_idx] : 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            ofm_c_q     <= '0;
            wpp_q       <= '0;
            npix_m1_q   <= '0;
            last_t_q    <= '0;
            last_kmax_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            k_q         <= '0;
            p_q         <= '0;
            t_q         <= '0;
            pix_addr_q  <= '0;
            cap_p_q     <= '0;
            cap_t_q     <= '0;
            cap_all_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            k_q        <= k_d;
            p_q        <= p_d;
            t_q        <= t_d;
            pix_addr_q <= pix_addr_d;
            cap_p_q    <= cap_p_d;
            cap_t_q    <= cap_t_d;
            cap_all_q  <= cap_all_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            overflow_q <= overflow_d;
            if (start_go) begin
                base_q                     <= base_addr;
                ofm_c_q                    <= OFM_C;
                wpp_q                      <= 7'((9'(OFM_C) + 9'd3) >> 2);
                npix_m1_q                  <= 16'(OFM_W) * 16'(OFM_W) - 16'd1;
                {last_t_q, last_kmax_q}    <= 6'((OFM_C - 8'd1) >> 2);
            end
        end
    end

    // NOTE: the FIFO storage is not reset; the cleared count/pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= in_set;
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign overflow = overflow_q;

endmodule
